imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer in front of the combinational instruction ROM.
- Owns the PC and drives the ROM address.
- Buffers fetched words with their PCs in a small FIFO, presented to decode over a valid/ready handshake.
- Handles branch redirects, external halt, and end-of-memory. Decouples decode stalls from ROM access for the pipelined CPU.

Parameters:
- MEM_SIZE, 1024: ROM size in bytes; power of two, >4; must match the ROM.
- RESET_PC, 0: PC loaded on reset; word-aligned.
- DEPTH, 2: fetch FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_address  out  64  byte address to ROM; always equals the PC register.
- imem_instruction  in  32  ROM read data; combinational from imem_address.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  64  redirect target (byte address).
- halt  in  1  level; suppresses new fetches while high.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_instruction  out  32  head instruction.
- out_pc  out  64  PC of head instruction.
- fault  out  1  present only with IFETCH_FAULT_EN.

Behaviour:
- Reset (sync, highest priority):
  - pc=RESET_PC, count=0, rd/wr pointers=0, state=RUN.
  - out_valid=0; out_instruction=0 and out_pc=0 (storage cleared); fault=0.
  - Reset asserted mid-operation discards all buffered entries the same edge.
- FSM states:
  - RUN: normal fetch.
  - HALTED: no fetch.
  - FAULT: only with macro.
- FSM transitions:
  - RUN→HALTED when halt=1.
  - HALTED→RUN when halt=0.
  - redirect_valid does not change HALTED.
- Derived signals:
  - deq = out_valid & out_ready.
  - fire = (state==RUN) & !halt & !redirect_valid & (count<DEPTH | deq).
- fire: push {pc, imem_instruction} at wr pointer; pc <= pc+4. Latency: ROM word visible on out_* the cycle after fire.
- deq: pop head. Simultaneous fire+deq keeps count unchanged; allowed when full.
- out_valid = (count!=0), driven from registered count. out_instruction/out_pc come from head storage.
- Redirect (any state but reset; priority over fire):
  - Flush FIFO (count=0, pointers=0).
  - pc <= redirect_pc.
  - A deq in the same cycle still counts as a completed transfer (sink sees it).
- halt: buffered entries keep draining via deq; the PC is held.
- Boundaries:
  - Empty: out_valid=0, out_* hold last value (don't-care).
  - Full with out_ready=0: no fire; pc held.
- End-of-memory (without macro):
  - pc+4 wraps modulo MEM_SIZE (last word 1020 → 0).
  - redirect_pc low 2 bits forced to 0, then taken modulo MEM_SIZE.
- Counters: count is clog2(DEPTH)+1 bits. Pointers are clog2(DEPTH) bits and wrap naturally.

Optional Feature:
IFETCH_FAULT_EN
- Defined:
  - Adds port fault and state FAULT.
  - Entering FAULT instead of fetching occurs when either:
    - in RUN, pc[1:0]!=0 or pc+3 ≥ MEM_SIZE;
    - redirect_pc is misaligned or out of range (pc still loaded).
  - No wrap or masking.
  - FAULT: fault=1, no fire, FIFO still drains.
  - Exit only on reset, or on a redirect to a legal address → RUN with fault=0 next cycle.
- Undefined: no fault port; wrap/mask rules above.

Decomposition:
- Package imem_fetch_pkg:
  - fetch_state_e enum (RUN, HALTED, FAULT).
  - fetch_entry_t struct {pc[63:0], instruction[31:0]}.
  - constant WORD_BYTES=4.
- Sub-module fetch_fifo: parameterised DEPTH, sync reset, push/pop/count, storing fetch_entry_t. The controller instantiates it once.

Test Plan:
- Reset then out_ready=1 with ROM word k = k: out_pc = 0,4,8,… one per cycle from cycle 2; out_instruction matches; out_valid rises one cycle after reset release.
- out_ready=0 for 5 cycles: after 2 fires count=2, pc=8 and held, imem_address=8; out_ready=1 → entries 0,4 then 8 delivered with no loss or duplicate.
- Redirect to 0x40 while FIFO holds {0,4}, out_ready=1 that cycle: entry 0 transferred; next cycle out_valid=0, then out_pc=0x40, 0x44.
- halt=1 for 4 cycles with full FIFO: pc frozen; two entries drain; halt=0 → fetch resumes at same pc.
- Start at 1016 via redirect: out_pc 1016, 1020, 0 (no macro). With IFETCH_FAULT_EN: after 1020, fault=1 and no further valid; redirect to 0 clears fault.
- Assert reset with FIFO full: next cycle out_valid=0, imem_address=RESET_PC, count=0.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// imem_fetch_pkg: shared types for the instruction-fetch front end.
//   fetch_state_e : sequencer state (RUN / HALTED / FAULT)
//   fetch_entry_t : one buffered fetch, instruction word plus its byte PC
//   WORD_BYTES    : PC increment per fetched word
package imem_fetch_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_entry_t between ROM access and decode.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears storage too)
//   flush        : drop every entry, pointers back to 0 (wins over push/pop)
//   push, pop    : write push_entry at tail / advance head; caller keeps
//                  push off when full (unless popping) and pop off when empty
//   push_entry   : entry to store
//   head         : entry at the read pointer (stale when count==0)
//   count        : number of valid entries, 0..DEPTH
module fetch_fifo
  import imem_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;   // power-of-two depth: wraps naturally
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer in front of a combinational ROM.
// Owns the PC, reads one word per fetch and buffers {pc, word} for decode.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   imem_address            : ROM byte address (the PC register)
//   imem_instruction        : ROM data, combinational from imem_address
//   redirect_valid/_pc      : branch/jump redirect, flushes the buffer
//   halt                    : level, freezes fetching (buffer still drains)
//   out_valid/ready/instruction/pc : decode handshake on the buffer head
//   fault                   : only with IFETCH_FAULT_EN
// Build option IFETCH_FAULT_EN: out-of-range or misaligned PCs/redirects
// enter FAULT instead of wrapping/masking; default build wraps modulo MEM_SIZE.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int          MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [63:0] out_pc
`ifdef IFETCH_FAULT_EN
  ,
  output logic        fault
`endif
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [63:0] MEM_MASK = 64'(MEM_SIZE - 1);

  fetch_state_e  state, state_d;
  logic [63:0]   pc, pc_seq, redir_pc;
  logic [CW-1:0] count;
  logic          deq, fire;
  fetch_entry_t  push_entry, head;

  assign imem_address    = pc;
  assign out_valid       = (count != '0);
  assign deq             = out_valid & out_ready;
  assign out_instruction = head.instruction;
  assign out_pc          = head.pc;
  assign push_entry      = '{pc: pc, instruction: imem_instruction};

`ifdef IFETCH_FAULT_EN
  logic pc_bad, redir_bad;

  // Word must fit entirely below MEM_SIZE; 65-bit sums avoid wrap on huge PCs.
  assign pc_bad    = (pc[1:0] != 2'b00) |
                     (({1'b0, pc} + 65'd3) >= 65'(MEM_SIZE));
  assign redir_bad = (redirect_pc[1:0] != 2'b00) |
                     (({1'b0, redirect_pc} + 65'd3) >= 65'(MEM_SIZE));
  assign pc_seq    = pc + 64'(WORD_BYTES);
  assign redir_pc  = redirect_pc;
  assign fire      = (state == RUN) & ~halt & ~redirect_valid & ~pc_bad &
                     ((count != FULL_CNT) | deq);
  assign fault     = (state == FAULT);
`else
  assign pc_seq    = (pc + 64'(WORD_BYTES)) & MEM_MASK;
  assign redir_pc  = redirect_pc & ~64'd3 & MEM_MASK;
  assign fire      = (state == RUN) & ~halt & ~redirect_valid &
                     ((count != FULL_CNT) | deq);
`endif

  always_comb begin
    state_d = state;
    case (state)
      RUN:     if (halt)  state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = state;
    endcase
`ifdef IFETCH_FAULT_EN
    // A bad PC faults only at the point it would otherwise have been fetched.
    if (state == RUN && !halt && !redirect_valid && pc_bad) state_d = FAULT;
    if (redirect_valid) begin
      if (redir_bad)            state_d = FAULT;
      else if (state == FAULT)  state_d = RUN;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      state <= state_d;
      if (redirect_valid) pc <= redir_pc;
      else if (fire)      pc <= pc_seq;
    end
  end

  // Redirect flushes; a head popped on the same edge still counts as delivered.
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (fire),
    .pop        (deq),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

endmodule
